// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access; data access wins
// unless it has starved fetch for MAX_DM_STREAK grants. Optional watchdog: ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int MAX_DM_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam int                  STREAK_W   = $clog2(MAX_DM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    state_t              state_r, state_s;
    logic [STREAK_W-1:0] streak_r, streak_s;
    logic                if_valid_s, dm_valid_s, mem_req_s, mem_we_s, busy_s, err_s;
    logic [31:0]         if_rdata_s;
    logic [DATA_W-1:0]   dm_rdata_s, mem_wdata_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic                grant_block_s;

`ifdef ARB_TIMEOUT_EN
    localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wd_r, wd_s;
    logic            to_if_r, to_if_s, to_dm_r, to_dm_s;
`endif

    // Next-state, grant decision and next values of every registered output
    always_comb begin
        state_s       = state_r;
        streak_s      = streak_r;
        mem_req_s     = mem_req;
        mem_we_s      = mem_we;
        mem_addr_s    = mem_addr;
        mem_wdata_s   = mem_wdata;
        if_valid_s    = 1'b0;
        if_rdata_s    = 32'h0;
        dm_valid_s    = 1'b0;
        dm_rdata_s    = '0;
        err_s         = 1'b0;
        grant_block_s = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wd_s    = '0;
        to_if_s = 1'b0;
        to_dm_s = 1'b0;
        // A timed-out access reports one cycle after leaving BUSY; no grant meanwhile
        if (to_if_r || to_dm_r) begin
            grant_block_s = 1'b1;
            if_valid_s    = to_if_r;
            dm_valid_s    = to_dm_r;
            err_s         = 1'b1;
        end else begin
            grant_block_s = 1'b0;
        end
`endif
        case (state_r)
            IDLE: begin
                if (!grant_block_s && dm_req && (!if_req || (streak_r < STREAK_MAX))) begin
                    state_s     = BUSY_DM;
                    mem_req_s   = 1'b1;
                    mem_we_s    = dm_we;
                    mem_addr_s  = dm_addr;
                    mem_wdata_s = dm_wdata;
                    if (if_req) begin
                        streak_s = (streak_r == STREAK_MAX) ? streak_r : streak_r + STREAK_W'(1);
                    end else begin
                        streak_s = '0;
                    end
                end else if (!grant_block_s && if_req) begin
                    state_s     = BUSY_IF;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = if_addr;
                    mem_wdata_s = '0;
                    streak_s    = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ready) begin
                    state_s   = IDLE;
                    mem_req_s = 1'b0;
                    if (state_r == BUSY_IF) begin
                        if_valid_s = 1'b1;
                        if_rdata_s = mem_rdata[31:0];
                    end else begin
                        dm_valid_s = 1'b1;
                        dm_rdata_s = mem_rdata;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (wd_r == TO_LAST) begin
                        state_s   = IDLE;
                        mem_req_s = 1'b0;
                        to_if_s   = (state_r == BUSY_IF);
                        to_dm_s   = (state_r == BUSY_DM);
                    end else begin
                        wd_s = wd_r + TO_W'(1);
                    end
`else
                    state_s = state_r;
`endif
                end
            end
            default: begin
                state_s   = IDLE;
                mem_req_s = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Streak counter and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            streak_r  <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= 32'h0;
            dm_valid  <= 1'b0;
            dm_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            streak_r  <= streak_s;
            if_valid  <= if_valid_s;
            if_rdata  <= if_rdata_s;
            dm_valid  <= dm_valid_s;
            dm_rdata  <= dm_rdata_s;
            mem_req   <= mem_req_s;
            mem_we    <= mem_we_s;
            mem_addr  <= mem_addr_s;
            mem_wdata <= mem_wdata_s;
            busy      <= busy_s;
            err       <= err_s;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter and pending-timeout flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_r    <= '0;
            to_if_r <= 1'b0;
            to_dm_r <= 1'b0;
        end else begin
            wd_r    <= wd_s;
            to_if_r <= to_if_s;
            to_dm_r <= to_dm_s;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder, requester models and
// per-requester expected-data queues, all driven from one initial block.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
    logic [63:0] if_addr = 64'h0, dm_addr = 64'h0, dm_wdata = 64'h0, mem_rdata = 64'h0;
    logic        if_valid, dm_valid, mem_req, mem_we, busy, err;
    logic [31:0] if_rdata;
    logic [63:0] dm_rdata, mem_addr, mem_wdata;

    mem_port_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          cyc;
    } grant_t;

    grant_t      glog[$];
    logic [63:0] if_q[$];
    logic [63:0] dm_q[$];
    int          n_assert = 0, n_fail = 0, cyc = 0;
    int          mem_wait = 0, wait_cnt = 0;
    bit          acc_active = 1'b0, ready_en = 1'b1, ready_idle = 1'b0;
    int          if_more = 0, dm_more = 0, if_cnt = 0, dm_cnt = 0;
    bit          prev_if_v = 1'b0, prev_dm_v = 1'b0;
    logic        exp_err = 1'b0;

    function automatic logic [63:0] rdata_for(input logic [63:0] a);
        if (a == 64'h8) return 64'h0000_0000_0050_0093;
        return {~a[31:0], a[31:0] + 32'h0000_1234};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {58'h0, if_valid, dm_valid, mem_req, mem_we, busy, err}, 64'h0);
        chk({tag, "_if_rdata"}, {32'h0, if_rdata}, 64'h0);
        chk({tag, "_dm_rdata"}, dm_rdata, 64'h0);
        chk({tag, "_mem_addr"}, mem_addr, 64'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    endtask

    // One clock: sample after the edge, run memory model and requester models
    task automatic tick();
        logic [63:0] e;
        @(posedge clock);
        #1;
        cyc++;
        if (mem_req) begin
            if (!acc_active) begin
                acc_active = 1'b1;
                wait_cnt   = 0;
                glog.push_back('{mem_we, mem_addr, mem_wdata, cyc});
            end else begin
                chk("mem_addr_hold", mem_addr, glog[$].addr);
                chk("mem_wdata_hold", mem_wdata, glog[$].wdata);
                chk("mem_we_hold", {63'h0, mem_we}, {63'h0, glog[$].we});
            end
            if (ready_en && wait_cnt >= mem_wait) begin
                mem_ready = 1'b1;
                mem_rdata = rdata_for(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 64'h0;
                wait_cnt++;
            end
        end else begin
            acc_active = 1'b0;
            mem_ready  = ready_idle;
            mem_rdata  = ready_idle ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
        end
        if (if_valid) begin
            if_cnt++;
            chk("if_valid_one_cycle", {63'h0, prev_if_v}, 64'h0);
            chk("err_on_if_valid", {63'h0, err}, {63'h0, exp_err});
            if (if_q.size() == 0) begin
                chk("if_valid_unexpected", {63'h0, if_valid}, 64'h0);
            end else begin
                e = if_q.pop_front();
                chk("if_rdata", {32'h0, if_rdata}, {32'h0, e[31:0]});
            end
            if (if_more > 0) begin
                if_more--;
                if_addr = if_addr + 64'h4;
                if_q.push_back(rdata_for(if_addr));
            end else begin
                if_req = 1'b0;
            end
        end else if (prev_if_v) begin
            chk("if_rdata_clear", {32'h0, if_rdata}, 64'h0);
        end
        if (dm_valid) begin
            dm_cnt++;
            chk("dm_valid_one_cycle", {63'h0, prev_dm_v}, 64'h0);
            chk("err_on_dm_valid", {63'h0, err}, {63'h0, exp_err});
            if (dm_q.size() == 0) begin
                chk("dm_valid_unexpected", {63'h0, dm_valid}, 64'h0);
            end else begin
                e = dm_q.pop_front();
                chk("dm_rdata", dm_rdata, e);
            end
            if (dm_more > 0) begin
                dm_more--;
                dm_addr  = dm_addr + 64'h8;
                dm_wdata = dm_wdata + 64'h1;
                dm_q.push_back(rdata_for(dm_addr));
            end else begin
                dm_req = 1'b0;
            end
        end else if (prev_dm_v) begin
            chk("dm_rdata_clear", dm_rdata, 64'h0);
        end
        prev_if_v = if_valid;
        prev_dm_v = dm_valid;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((if_q.size() != 0 || dm_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", {63'h0, (if_q.size() == 0 && dm_q.size() == 0 && !busy)}, 64'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int c0;
        int exp_dm[8];
        exp_dm = '{1, 1, 1, 1, 0, 1, 1, 0};

        // reset state
        #12;
        check_all_zero("reset");
        @(posedge clock);
        #3 reset_n = 1'b1;
        tick();

        // lone fetch: req at cycle 0, ready at cycle 2, valid at cycle 3
        glog.delete();
        mem_wait = 1;
        if_addr  = 64'h8;
        if_req   = 1'b1;
        if_q.push_back(rdata_for(64'h8));
        tick();
        chk("t1_mem_req_c1", {63'h0, mem_req}, 64'h1);
        chk("t1_mem_addr", mem_addr, 64'h8);
        chk("t1_mem_we", {63'h0, mem_we}, 64'h0);
        chk("t1_busy_c1", {63'h0, busy}, 64'h1);
        tick();
        chk("t1_if_valid_c2", {63'h0, if_valid}, 64'h0);
        tick();
        chk("t1_if_valid_c3", {63'h0, if_valid}, 64'h1);
        chk("t1_if_rdata", {32'h0, if_rdata}, 64'h0050_0093);
        chk("t1_mem_req_c3", {63'h0, mem_req}, 64'h0);
        tick();
        chk("t1_if_valid_c4", {63'h0, if_valid}, 64'h0);
        chk("t1_busy_c4", {63'h0, busy}, 64'h0);

        // mem_ready while idle is ignored
        ready_idle = 1'b1;
        repeat (3) tick();
        chk("idle_ready_busy", {63'h0, busy}, 64'h0);
        chk("idle_ready_mem_req", {63'h0, mem_req}, 64'h0);
        ready_idle = 1'b0;
        tick();

        // contention: DM store first, then fetch
        glog.delete();
        mem_wait = 0;
        if_addr  = 64'h10;
        if_req   = 1'b1;
        if_q.push_back(rdata_for(64'h10));
        dm_addr  = 64'h100;
        dm_we    = 1'b1;
        dm_wdata = 64'hAB;
        dm_req   = 1'b1;
        dm_q.push_back(rdata_for(64'h100));
        wait_idle(20);
        chk("t2_grants", 64'(glog.size()), 64'd2);
        if (glog.size() >= 2) begin
            chk("t2_first_we", {63'h0, glog[0].we}, 64'h1);
            chk("t2_first_addr", glog[0].addr, 64'h100);
            chk("t2_first_wdata", glog[0].wdata, 64'hAB);
            chk("t2_second_addr", glog[1].addr, 64'h10);
            chk("t2_second_we", {63'h0, glog[1].we}, 64'h0);
            chk("t2_second_wdata", glog[1].wdata, 64'h0);
        end

        // starvation limit: DDDD I DD I, one grant every 2 cycles
        glog.delete();
        dm_we    = 1'b0;
        if_addr  = 64'h1000;
        if_more  = 1;
        if_req   = 1'b1;
        if_q.push_back(rdata_for(64'h1000));
        dm_addr  = 64'h200;
        dm_more  = 5;
        dm_req   = 1'b1;
        dm_q.push_back(rdata_for(64'h200));
        wait_idle(60);
        chk("t3_grants", 64'(glog.size()), 64'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            chk($sformatf("t3_grant%0d_is_dm", i), {63'h0, glog[i].addr < 64'h1000},
                64'(exp_dm[i]));
            if (i > 0) chk($sformatf("t3_spacing%0d", i), 64'(glog[i].cyc - glog[i-1].cyc), 64'd2);
        end
        tick();

        // wait states: 5 cycles of mem_ready low on a store
        glog.delete();
        mem_wait = 5;
        c0       = dm_cnt;
        dm_we    = 1'b1;
        dm_addr  = 64'h300;
        dm_wdata = 64'hDEAD;
        dm_req   = 1'b1;
        dm_q.push_back(rdata_for(64'h300));
        wait_idle(30);
        chk("t4_one_dm_valid", 64'(dm_cnt - c0), 64'd1);
        chk("t4_single_grant", 64'(glog.size()), 64'd1);
        tick();

        // reset in the middle of a fetch
        mem_wait = 20;
        if_addr  = 64'h40;
        if_req   = 1'b1;
        if_q.push_back(rdata_for(64'h40));
        tick();
        tick();
        chk("t5_busy_before_reset", {63'h0, busy}, 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("t5_async_reset");
        if_req     = 1'b0;
        if_q.delete();
        acc_active = 1'b0;
        mem_ready  = 1'b0;
        @(posedge clock);
        #3 reset_n = 1'b1;
        c0 = if_cnt;
        repeat (5) tick();
        chk("t5_no_if_valid", 64'(if_cnt - c0), 64'd0);
        chk("t5_idle_after_release", {63'h0, busy}, 64'h0);
        mem_wait = 0;

`ifdef ARB_TIMEOUT_EN
        // watchdog: no mem_ready, err and dm_valid at cycle 18
        ready_en = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 64'h500;
        dm_req   = 1'b1;
        dm_q.push_back(64'h0);
        exp_err  = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("t6_no_valid_early", {63'h0, dm_valid}, 64'h0);
            chk("t6_no_err_early", {63'h0, err}, 64'h0);
        end
        chk("t6_mem_req_dropped", {63'h0, mem_req}, 64'h0);
        chk("t6_idle_c17", {63'h0, busy}, 64'h0);
        tick();
        chk("t6_dm_valid_c18", {63'h0, dm_valid}, 64'h1);
        chk("t6_err_c18", {63'h0, err}, 64'h1);
        chk("t6_dm_rdata_zero", dm_rdata, 64'h0);
        exp_err  = 1'b0;
        ready_en = 1'b1;
        tick();
        chk("t6_err_cleared", {63'h0, err}, 64'h0);
`else
        // no watchdog: BUSY waits indefinitely, err stays 0
        ready_en = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 64'h500;
        dm_req   = 1'b1;
        dm_q.push_back(rdata_for(64'h500));
        c0 = dm_cnt;
        repeat (25) tick();
        chk("t6_still_busy", {63'h0, busy}, 64'h1);
        chk("t6_mem_req_held", {63'h0, mem_req}, 64'h1);
        chk("t6_err_zero", {63'h0, err}, 64'h0);
        chk("t6_no_dm_valid", 64'(dm_cnt - c0), 64'd0);
        ready_en = 1'b1;
        wait_idle(10);
        chk("t6_completed", 64'(dm_cnt - c0), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
